// File: rtl/load_store_unit_pkg.sv
// Shared funct3 encodings and FSM state type for the load/store unit.
package lsu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } lsu_state_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Core request / data-memory port bundle; slave = LSU side, master = core+memory side.
interface lsu_if;
    import lsu_pkg::*;

    logic            req_valid;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            stall;
    logic [XLEN-1:0] load_data;
    logic            misaligned_err;
    logic [XLEN-1:0] mem_addr;
    logic            mem_re;
    logic            mem_we;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output stall, load_data, misaligned_err, mem_addr, mem_re, mem_we, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  stall, load_data, misaligned_err, mem_addr, mem_re, mem_we, mem_wdata
    );
endinterface

// File: rtl/load_store_unit_lane_align.sv
// Byte-lane steering: store merge into the read word and load extract/extend.
// The access is viewed as a 64-bit window {upper word, lower word}; phase picks the word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic            i_phase,
    input  logic [1:0]      i_offset,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_rdata,
    input  logic [XLEN-1:0] i_lo_buf,
    output logic [2:0]      o_size_c,
    output logic [XLEN-1:0] o_wdata_c,
    output logic [XLEN-1:0] o_load_c
);

    logic [3:0]      w_len_mask;
    logic [7:0]      w_lanes;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_bmask;
    logic [63:0]     w_wshift;
    logic [XLEN-1:0] w_wpart;
    logic [63:0]     w_rd64;
    logic [XLEN-1:0] w_raw;

    // Access size from funct3[1:0]; unused codes fall back to a full word.
    always_comb begin
        o_size_c   = 3'd4;
        w_len_mask = 4'b1111;
        case (i_funct3[1:0])
            2'b00:   begin o_size_c = 3'd1; w_len_mask = 4'b0001; end
            2'b01:   begin o_size_c = 3'd2; w_len_mask = 4'b0011; end
            default: begin o_size_c = 3'd4; w_len_mask = 4'b1111; end
        endcase
    end

    // Store path: shift data to its lanes and merge under this phase's byte enables.
    always_comb begin
        w_lanes  = 8'(w_len_mask) << i_offset;
        w_be     = i_phase ? w_lanes[7:4] : w_lanes[3:0];
        w_wshift = 64'(i_wdata) << {i_offset, 3'b000};
        w_wpart  = i_phase ? w_wshift[63:32] : w_wshift[31:0];
        w_bmask  = '0;
        for (int b = 0; b < 4; b++) begin
            w_bmask[b*8 +: 8] = {8{w_be[b]}};
        end
        o_wdata_c = (i_rdata & ~w_bmask) | (w_wpart & w_bmask);
    end

    // Load path: in the second phase the low bytes come from the buffered first word.
    always_comb begin
        w_rd64 = i_phase ? {i_rdata, i_lo_buf} : {32'h0, i_rdata};
        w_raw  = 32'(w_rd64 >> {i_offset, 3'b000});
        case (i_funct3[1:0])
            2'b00:   o_load_c = i_funct3[2] ? {24'h0, w_raw[7:0]}  : {{24{w_raw[7]}},  w_raw[7:0]};
            2'b01:   o_load_c = i_funct3[2] ? {16'h0, w_raw[15:0]} : {{16{w_raw[15]}}, w_raw[15:0]};
            default: o_load_c = w_raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: word-port translation, RMW sub-word stores, two-phase crossing accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter bit MISALIGNED_EN = 1'b1
) (
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);

    lsu_state_t      r_state;
    lsu_state_t      w_state_nxt;
    logic [XLEN-1:0] r_lo_buf;
    logic [XLEN-1:0] w_lo_nxt;

    logic [1:0]      w_offset;
    logic [2:0]      w_size;
    logic            w_phase;
    logic            w_cross;
    logic            w_misal;
    logic            w_err;
    logic [XLEN-1:0] w_merged;
    logic [XLEN-1:0] w_load;

    assign w_offset = bus.req_addr[1:0];
    assign w_phase  = (r_state == SECOND);
    assign w_cross  = (3'(w_offset) + w_size) > 3'd4;

    lsu_lane_align u_lane_align (
        .i_phase   (w_phase),
        .i_offset  (w_offset),
        .i_funct3  (bus.req_funct3),
        .i_wdata   (bus.req_wdata),
        .i_rdata   (bus.mem_rdata),
        .i_lo_buf  (r_lo_buf),
        .o_size_c  (w_size),
        .o_wdata_c (w_merged),
        .o_load_c  (w_load)
    );

    // Natural-alignment test: offset must be a multiple of the access size.
    always_comb begin
        case (w_size)
            3'd1:    w_misal = 1'b0;
            3'd2:    w_misal = w_offset[0];
            default: w_misal = (w_offset != 2'b00);
        endcase
        w_err = !MISALIGNED_EN && bus.req_valid && w_misal && !rst;
    end

    // State and first-word load buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_lo_buf <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_lo_buf <= w_lo_nxt;
        end
    end

    // Next state and memory-port / core-side outputs; reset forces everything quiet.
    always_comb begin
        w_state_nxt        = r_state;
        w_lo_nxt           = r_lo_buf;
        bus.stall          = 1'b0;
        bus.load_data      = '0;
        bus.misaligned_err = w_err;
        bus.mem_addr       = {bus.req_addr[31:2], 2'b00};
        bus.mem_re         = 1'b0;
        bus.mem_we         = 1'b0;
        bus.mem_wdata      = w_merged;

        if (r_state == SECOND) begin
            w_state_nxt  = IDLE;
            bus.mem_addr = {bus.req_addr[31:2] + 30'd1, 2'b00};
            if (bus.req_valid && !rst) begin
                bus.mem_re = 1'b1;
                bus.mem_we = bus.req_we;
                if (!bus.req_we) begin
                    bus.load_data = w_load;
                end
            end
        end else if (bus.req_valid && !rst && !w_err) begin
            bus.mem_re = !bus.req_we || !(w_size == 3'd4 && w_offset == 2'b00);
            bus.mem_we = bus.req_we;
            if (MISALIGNED_EN && w_cross) begin
                bus.stall   = 1'b1;
                w_state_nxt = SECOND;
                if (!bus.req_we) begin
                    w_lo_nxt = bus.mem_rdata;
                end
            end else if (!bus.req_we) begin
                bus.load_data = w_load;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: table-driven aligned loads plus directed multi-cycle sequences.
`timescale 1ns/1ps
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk;
    logic rst;
    logic preload;
    int   checks;
    int   failures;

    logic [31:0] mem_a [0:3];
    logic [31:0] mem_b [0:3];

    lsu_if ia ();
    lsu_if ib ();

    load_store_unit #(.MISALIGNED_EN(1'b1)) u_dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
    load_store_unit #(.MISALIGNED_EN(1'b0)) u_dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-addressed memories: combinational read, write on the rising edge.
    assign ia.mem_rdata = mem_a[ia.mem_addr[3:2]];
    assign ib.mem_rdata = mem_b[ib.mem_addr[3:2]];

    always @(posedge clk) begin
        if (preload) begin
            mem_a[0] <= 32'h44332211; mem_a[1] <= 32'h88776655;
            mem_a[2] <= 32'h0;        mem_a[3] <= 32'h0;
            mem_b[0] <= 32'h44332211; mem_b[1] <= 32'h88776655;
            mem_b[2] <= 32'h0;        mem_b[3] <= 32'h0;
        end else begin
            if (ia.mem_we) mem_a[ia.mem_addr[3:2]] <= ia.mem_wdata;
            if (ib.mem_we) mem_b[ib.mem_addr[3:2]] <= ib.mem_wdata;
        end
    end

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] exp_load;
        logic [31:0] exp_maddr;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic v, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd);
        ia.req_valid = v; ia.req_we = we; ia.req_funct3 = f3; ia.req_addr = addr; ia.req_wdata = wd;
        ib.req_valid = v; ib.req_we = we; ib.req_funct3 = f3; ib.req_addr = addr; ib.req_wdata = wd;
    endtask

    task automatic reload();
        @(negedge clk);
        set_req(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        preload = 1'b1;
        @(posedge clk);
        #1 preload = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        preload  = 1'b0;
        rst      = 1'b1;
        set_req(1'b1, 1'b0, F3_W, 32'h2, 32'h0);

        vecs[0] = '{F3_W,    32'd0, 32'h44332211, 32'd0};
        vecs[1] = '{F3_B,    32'd7, 32'hFFFFFF88, 32'd4};
        vecs[2] = '{F3_BU,   32'd7, 32'h00000088, 32'd4};
        vecs[3] = '{F3_H,    32'd2, 32'h00004433, 32'd0};
        vecs[4] = '{F3_H,    32'd6, 32'hFFFF8877, 32'd4};
        vecs[5] = '{F3_HU,   32'd6, 32'h00008877, 32'd4};
        vecs[6] = '{F3_H,    32'd1, 32'h00003322, 32'd0};
        vecs[7] = '{3'b011,  32'd4, 32'h88776655, 32'd4};
        vecs[8] = '{F3_B,    32'd5, 32'h00000066, 32'd4};

        // Outputs held quiet while reset is high, even with a request present.
        #3;
        check("rst_stall",   32'(ia.stall), 32'd0);
        check("rst_mem_re",  32'(ia.mem_re), 32'd0);
        check("rst_mem_we",  32'(ia.mem_we), 32'd0);
        check("rst_load",    ia.load_data, 32'd0);
        check("rst_err_b",   32'(ib.misaligned_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        reload();

        // Single-cycle loads from the table.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            set_req(1'b1, 1'b0, vecs[i].f3, vecs[i].addr, 32'h0);
            #1;
            check($sformatf("vec%0d_load", i),  ia.load_data, vecs[i].exp_load);
            check($sformatf("vec%0d_stall", i), 32'(ia.stall), 32'd0);
            check($sformatf("vec%0d_maddr", i), ia.mem_addr, vecs[i].exp_maddr);
            check($sformatf("vec%0d_re", i),    32'(ia.mem_re), 32'd1);
            check($sformatf("vec%0d_we", i),    32'(ia.mem_we), 32'd0);
        end

        // SB @1: single-cycle RMW.
        @(negedge clk);
        set_req(1'b1, 1'b1, F3_B, 32'd1, 32'h000000AB);
        #1;
        check("sb_stall", 32'(ia.stall), 32'd0);
        check("sb_re",    32'(ia.mem_re), 32'd1);
        check("sb_we",    32'(ia.mem_we), 32'd1);
        check("sb_wdata", ia.mem_wdata, 32'h4433AB11);
        @(negedge clk);
        set_req(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        #1;
        check("sb_mem0",  mem_a[0], 32'h4433AB11);
        check("idle_re",  32'(ia.mem_re), 32'd0);
        check("idle_load", ia.load_data, 32'd0);

        // Crossing loads: LW @2 and LH @3.
        reload();
        @(negedge clk);
        set_req(1'b1, 1'b0, F3_W, 32'd2, 32'h0);
        #1;
        check("lw2_c1_stall", 32'(ia.stall), 32'd1);
        check("lw2_c1_maddr", ia.mem_addr, 32'd0);
        @(negedge clk);
        #1;
        check("lw2_c2_stall", 32'(ia.stall), 32'd0);
        check("lw2_c2_maddr", ia.mem_addr, 32'd4);
        check("lw2_c2_load",  ia.load_data, 32'h66554433);
        @(negedge clk);
        set_req(1'b1, 1'b0, F3_H, 32'd3, 32'h0);
        #1;
        check("lh3_c1_stall", 32'(ia.stall), 32'd1);
        @(negedge clk);
        #1;
        check("lh3_c2_stall", 32'(ia.stall), 32'd0);
        check("lh3_c2_load",  ia.load_data, 32'h00005544);

        // Crossing store SW @3.
        reload();
        @(negedge clk);
        set_req(1'b1, 1'b1, F3_W, 32'd3, 32'hDEADBEEF);
        #1;
        check("sw3_c1_stall", 32'(ia.stall), 32'd1);
        check("sw3_c1_re",    32'(ia.mem_re), 32'd1);
        check("sw3_c1_wdata", ia.mem_wdata, 32'hEF332211);
        @(negedge clk);
        #1;
        check("sw3_mem0",     mem_a[0], 32'hEF332211);
        check("sw3_c2_stall", 32'(ia.stall), 32'd0);
        check("sw3_c2_maddr", ia.mem_addr, 32'd4);
        check("sw3_c2_wdata", ia.mem_wdata, 32'h88DEADBE);
        @(negedge clk);
        set_req(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        #1;
        check("sw3_mem1",     mem_a[1], 32'h88DEADBE);

        // Aligned SW writes without a read.
        @(negedge clk);
        set_req(1'b1, 1'b1, F3_W, 32'd8, 32'h12345678);
        #1;
        check("sw8_re", 32'(ia.mem_re), 32'd0);
        check("sw8_we", 32'(ia.mem_we), 32'd1);

        // SW @3 with reset pulsed during the second phase.
        reload();
        @(negedge clk);
        set_req(1'b1, 1'b1, F3_W, 32'd3, 32'hDEADBEEF);
        #1;
        check("rsw_c1_stall", 32'(ia.stall), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rsw_c2_stall", 32'(ia.stall), 32'd0);
        check("rsw_c2_we",    32'(ia.mem_we), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        set_req(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        @(negedge clk);
        check("rsw_mem0", mem_a[0], 32'hEF332211);
        check("rsw_mem1", mem_a[1], 32'h88776655);
        set_req(1'b1, 1'b0, F3_W, 32'd4, 32'h0);
        #1;
        check("rsw_lw4_stall", 32'(ia.stall), 32'd0);
        check("rsw_lw4_load",  ia.load_data, 32'h88776655);

        // Misalignment flagged when splitting is disabled.
        reload();
        @(negedge clk);
        set_req(1'b1, 1'b0, F3_W, 32'd2, 32'h0);
        #1;
        check("b_lw2_err",   32'(ib.misaligned_err), 32'd1);
        check("b_lw2_we",    32'(ib.mem_we), 32'd0);
        check("b_lw2_stall", 32'(ib.stall), 32'd0);
        check("b_lw2_load",  ib.load_data, 32'd0);
        @(negedge clk);
        set_req(1'b1, 1'b0, F3_H, 32'd2, 32'h0);
        #1;
        check("b_lh2_err",   32'(ib.misaligned_err), 32'd0);
        check("b_lh2_load",  ib.load_data, 32'h00004433);
        @(negedge clk);
        set_req(1'b1, 1'b1, F3_H, 32'd1, 32'h0000CAFE);
        #1;
        check("b_sh1_err",   32'(ib.misaligned_err), 32'd1);
        check("b_sh1_we",    32'(ib.mem_we), 32'd0);
        @(negedge clk);
        set_req(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        #1;
        check("b_mem0",      mem_b[0], 32'h44332211);
        check("b_idle_err",  32'(ib.misaligned_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sits between the core's execute stage and data_memory. Translates LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses on the word-addressed memory port.
- Sub-word stores use read-modify-write, because memory writes are whole words only.
- Load data is extracted and sign/zero-extended.
- Misaligned accesses that cross a word boundary are split into two consecutive word accesses. The core is stalled for one cycle while this happens.

Parameters:
MISALIGNED_EN, 1, 1 = split word-crossing accesses into two phases; 0 = flag misaligned_err and suppress the access.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  core presents a load/store this cycle
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RISC-V funct3 (size/sign)
req_addr  input  32  byte address
req_wdata  input  32  store data (low bytes significant)
stall  output  1  core must hold PC and the request stable
load_data  output  32  extended load result; valid when req_valid && !req_we && !stall
misaligned_err  output  1  access not naturally aligned while MISALIGNED_EN=0
mem_addr  output  32  word address to data_memory (bits [1:0] = 0)
mem_re  output  1  read enable to data_memory
mem_we  output  1  write enable to data_memory
mem_wdata  output  32  merged word to write
mem_rdata  input  32  combinational read data from data_memory

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Byte lanes are little-endian.
  - Offset o = req_addr[1:0]; size n = 1/2/4 from funct3[1:0].
  - Bytes o..o+n-1 are used; bytes at index ≥4 map to the next word at index-4.
  - A crossing access has o+n>4.
- Memory read is combinational and writes land on clk edge. Therefore every non-crossing access, including sub-word RMW stores, completes in one cycle with stall=0.
- FSM states:
  - IDLE: a crossing request with MISALIGNED_EN=1 → state SECOND.
    - mem_addr = {addr[31:2],2'b00}, stall=1.
    - Store: write lower part merged into mem_rdata.
    - Load: latch mem_rdata into lo_buf.
  - SECOND: mem_addr = {addr[31:2]+1,2'b00}; addition wraps modulo 2^32.
    - stall=0.
    - Store: write upper part merged.
    - Load: load_data assembled from lo_buf and mem_rdata.
    - → IDLE unconditionally.
- mem_re=1 for every valid load and every non-SW store (RMW). Aligned SW writes directly with mem_re=0.
- mem_we = req_valid && req_we && !misaligned_err.
- Extension:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes 32 bits.
  - Unused funct3 codes behave as LW/SW.
- MISALIGNED_EN=0: misaligned_err = req_valid && (o mod n ≠ 0), combinational. When set: mem_we=0, load_data=0, stall=0, FSM stays IDLE.
- req_valid=0: mem_re=mem_we=0, stall=0, load_data=0, no state change.
- Reset (async, any state):
  - state → IDLE; lo_buf → 0.
  - While rst is high: stall=0, mem_we=0, mem_re=0, load_data=0, misaligned_err=0.
  - Reset asserted during SECOND: the second write never occurs; the first write already committed is not undone.
- The core must not change the request while stall=1. Behaviour is undefined otherwise.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants: F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - State enum lsu_state_t {IDLE, SECOND}.
- Sub-module lsu_lane_align (combinational) provides:
  - Per-word byte-enable mask and shifted write data for a given phase.
  - Extraction and extension of read bytes.
- The top level holds the FSM, lo_buf and the memory-port muxing.

Test Plan:
- Memory preload: word0=0x44332211, word1=0x88776655.
1. Aligned loads:
   - LW @0 → load_data=0x44332211, stall=0, mem_addr=0.
   - LB @7 → 0xFFFFFF88.
   - LBU @7 → 0x00000088.
   - LH @2 → 0x00004433.
2. SB @1 data 0x000000AB → single cycle, stall=0; word0=0x4433AB11 after edge; mem_re=1 (RMW).
3. LW @2 → cycle1: stall=1, mem_addr=0. Cycle2: stall=0, mem_addr=4, load_data=0x66554433. LH @3 → 0x00005544 after one stall cycle.
4. SW @3 data 0xDEADBEEF → word0=0xEF332211 after cycle1, word1=0x88DEADBE after cycle2; stall high only in cycle1.
5. SW @3 with rst pulsed during cycle2 → word0=0xEF332211, word1 unchanged 0x88776655, stall=0, FSM IDLE. Next LW @4 returns 0x88776655 with no stall.
6. MISALIGNED_EN=0: LW @2 → misaligned_err=1, mem_we=0, stall=0, load_data=0; LH @2 → misaligned_err=0, normal.
